// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_pkg
// Purpose  : Shared FIFO/APB constants, register offsets and controller states.
// Revision : 1.0
// ============================================================================
package shared_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_THRESH = 4'h8;
    localparam logic [3:0] REG_CLEAR  = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        RESP = 2'd2
    } fifo_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_apb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_apb_ctrl_if
// Purpose  : APB3 bus bundle between the interconnect and the FIFO controller.
// Revision : 1.0
// ============================================================================
interface fifo_apb_ctrl_if #(
    parameter int ADDR_WIDTH = 4
) ();

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface
`default_nettype wire

// File: rtl/fifo_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_apb_ctrl
// Purpose  : APB3 slave that pushes/pops a FIFO and reports status and irq.
// Revision : 1.0
// ============================================================================
module fifo_apb_ctrl
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = shared_pkg::FIFO_DEPTH,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    fifo_apb_ctrl_if.slave             apb,
    output logic                       wr_en,
    output logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      din,
    input  wire logic [DATA_WIDTH-1:0] dout,
    input  wire logic                  full,
    input  wire logic                  empty,
    output logic                       irq
);

    localparam int                 LEVEL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(FIFO_DEPTH);

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = ADDR_WIDTH'(REG_DATA);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(REG_STATUS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_THRESH = ADDR_WIDTH'(REG_THRESH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CLEAR  = ADDR_WIDTH'(REG_CLEAR);

    fifo_ctrl_state_e        r_state;
    fifo_ctrl_state_e        w_next_state;
    logic [LEVEL_W-1:0]      r_level;
    logic [7:0]              r_thresh;
    logic                    r_ovf;
    logic                    r_udf;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic                    r_irq;

    logic                    w_access;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [31:0]             w_status;
    logic                    w_pready;
    logic                    w_pslverr;
    logic [31:0]             w_prdata;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_ovf_set;
    logic                    w_udf_set;
    logic                    w_thresh_we;
    logic                    w_clear_we;
    logic                    w_unused;

    // Gating with rst_n keeps every combinational output at its reset value
    // while reset is held, even if the master leaves an access phase up.
    assign w_access = apb.psel & apb.penable & rst_n;
    assign w_addr   = apb.paddr;
    assign w_status = {16'h0000, 8'(r_level), 4'h0, r_udf, r_ovf, full, empty};
    assign w_unused = ^apb.pwdata;

    always_comb begin
        w_next_state = r_state;
        w_pready     = 1'b0;
        w_pslverr    = 1'b0;
        w_prdata     = 32'h0;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_ovf_set    = 1'b0;
        w_udf_set    = 1'b0;
        w_thresh_we  = 1'b0;
        w_clear_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_addr == ADDR_DATA) begin
                        if (apb.pwrite) begin
                            w_pready = 1'b1;
                            if (full) begin
                                w_pslverr = 1'b1;
                                w_ovf_set = 1'b1;
                            end else begin
                                w_wr_en = 1'b1;
                            end
                        end else if (empty) begin
                            w_pready  = 1'b1;
                            w_pslverr = 1'b1;
                            w_udf_set = 1'b1;
                        end else begin
                            w_rd_en      = 1'b1;
                            w_next_state = POP;
                        end
                    end else if (w_addr == ADDR_STATUS) begin
                        w_pready = 1'b1;
                        if (apb.pwrite) w_pslverr = 1'b1;
                        else            w_prdata  = w_status;
                    end else if (w_addr == ADDR_THRESH) begin
                        w_pready = 1'b1;
                        if (apb.pwrite) w_thresh_we = 1'b1;
                        else            w_prdata    = 32'(r_thresh);
                    end else if (w_addr == ADDR_CLEAR) begin
                        w_pready = 1'b1;
                        if (apb.pwrite) w_clear_we = 1'b1;
                        else            w_pslverr  = 1'b1;
                    end else begin
                        w_pready  = 1'b1;
                        w_pslverr = 1'b1;
                    end
                end
            end
            POP: begin
                w_next_state = RESP;
            end
            RESP: begin
                w_pready     = 1'b1;
                w_prdata     = 32'(r_hold);
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // dout is registered by the FIFO, so it is valid in the cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == POP) begin
            r_hold <= dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_wr_en && (r_level != LEVEL_MAX)) begin
            r_level <= r_level + LEVEL_W'(1);
        end else if (w_rd_en && (r_level != '0)) begin
            r_level <= r_level - LEVEL_W'(1);
        end
    end

    // A new error in the same cycle as a CLEAR write keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= 8'h00;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_thresh_we) r_thresh <= apb.pwdata[7:0];
            if (w_ovf_set)                         r_ovf <= 1'b1;
            else if (w_clear_we && apb.pwdata[2])  r_ovf <= 1'b0;
            if (w_udf_set)                         r_udf <= 1'b1;
            else if (w_clear_we && apb.pwdata[3])  r_udf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_thresh != 8'h00) && (8'(r_level) >= r_thresh);
        end
    end

    assign apb.pready  = w_pready;
    assign apb.pslverr = w_pslverr;
    assign apb.prdata  = w_prdata;
    assign wr_en       = w_wr_en;
    assign rd_en       = w_rd_en;
    assign din         = w_wr_en ? apb.pwdata[DATA_WIDTH-1:0] : '0;
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_fifo_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_apb_ctrl
// Purpose  : Directed self-checking bench for fifo_apb_ctrl with a FIFO model.
// Revision : 1.0
// ============================================================================
module tb_fifo_apb_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] din;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;

    always #5 clk = ~clk;

    fifo_apb_ctrl_if #(.ADDR_WIDTH(4)) apb ();

    fifo_apb_ctrl #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .apb   (apb),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .irq   (irq)
    );

    // Eight-entry FIFO with registered read data, sharing rst_n.
    logic [15:0] mem [8];
    int          cnt;
    int          rp;
    int          wp;

    assign full  = (cnt == 8);
    assign empty = (cnt == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 0;
            rp   <= 0;
            wp   <= 0;
            dout <= 16'h0000;
        end else if (wr_en && cnt < 8) begin
            mem[wp] <= din;
            wp      <= (wp + 1) % 8;
            cnt     <= cnt + 1;
        end else if (rd_en && cnt > 0) begin
            dout <= mem[rp];
            rp   <= (rp + 1) % 8;
            cnt  <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called one step after a rising edge; returns one step after the edge
    // that follows the completing cycle.
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        apb.psel    = 1'b1;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        apb.penable = 1'b0;
        rdata       = 32'h0;
        err         = 1'b1;
        waits       = 0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (apb.pready) begin
                rdata = apb.prdata;
                err   = apb.pslverr;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (waits >= 16) check("pready_timeout", 32'(waits), 32'd0);
        @(posedge clk); #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [3:0] addr, input logic [31:0] wdata, output logic err);
        logic [31:0] d;
        int          w;
        apb_xfer(1'b1, addr, wdata, d, err, w);
    endtask

    task automatic apb_rd(input logic [3:0] addr, output logic [31:0] rdata,
                          output logic err, output int waits);
        apb_xfer(1'b0, addr, 32'h0, rdata, err, waits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          w;
        int          wr0;
        int          rd0;

        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = 4'h0;
        apb.pwdata  = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", apb.prdata, 32'h0);
        check("rst_ctrl", {27'h0, apb.pready, apb.pslverr, wr_en, rd_en, irq}, 32'h0);
        check("rst_din", {16'h0, din}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_rd(4'h4, rd, err, w);
        check("rst_status", rd, 32'h0000_0001);
        check("rst_status_err", {31'h0, err}, 32'h0);

        // Single push then pop
        wr0 = wr_cnt;
        apb_wr(4'h0, 32'h0000_A5A5, err);
        check("push_err", {31'h0, err}, 32'h0);
        check("push_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        rd0 = rd_cnt;
        apb_rd(4'h0, rd, err, w);
        check("pop_data", rd, 32'h0000_A5A5);
        check("pop_err", {31'h0, err}, 32'h0);
        check("pop_waits", 32'(w), 32'd2);
        check("pop_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        apb_rd(4'h4, rd, err, w);
        check("status_after_pop", rd, 32'h0000_0001);

        // Fill past full
        wr0 = wr_cnt;
        for (int i = 0; i < 9; i++) begin
            apb_wr(4'h0, 32'h100 + 32'(i), err);
            check($sformatf("fill_err_%0d", i), {31'h0, err}, (i == 8) ? 32'h1 : 32'h0);
        end
        check("fill_wr_pulses", 32'(wr_cnt - wr0), 32'd8);
        apb_rd(4'h4, rd, err, w);
        check("status_ovf_full", rd, 32'h0000_0806);
        apb_wr(4'hC, 32'h4, err);
        check("clear_ovf_err", {31'h0, err}, 32'h0);
        apb_rd(4'h4, rd, err, w);
        check("status_ovf_cleared", rd, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            apb_rd(4'h0, rd, err, w);
            check($sformatf("drain_%0d", i), rd, 32'h100 + 32'(i));
        end
        apb_rd(4'h4, rd, err, w);
        check("status_drained", rd, 32'h0000_0001);

        // Underflow
        rd0 = rd_cnt;
        apb_rd(4'h0, rd, err, w);
        check("udf_err", {31'h0, err}, 32'h1);
        check("udf_data", rd, 32'h0);
        check("udf_waits", 32'(w), 32'd0);
        check("udf_no_rd_en", 32'(rd_cnt - rd0), 32'd0);
        apb_rd(4'h4, rd, err, w);
        check("status_udf", rd, 32'h0000_0009);
        apb_wr(4'hC, 32'h8, err);
        apb_rd(4'h4, rd, err, w);
        check("status_udf_cleared", rd, 32'h0000_0001);

        // Illegal accesses
        apb_rd(4'h2, rd, err, w);
        check("unmapped_rd_err", {31'h0, err}, 32'h1);
        check("unmapped_rd_data", rd, 32'h0);
        apb_wr(4'h4, 32'hFFFF_FFFF, err);
        check("status_wr_err", {31'h0, err}, 32'h1);
        apb_rd(4'hC, rd, err, w);
        check("clear_rd_err", {31'h0, err}, 32'h1);

        // Threshold interrupt
        apb_wr(4'h8, 32'h3, err);
        check("thresh_wr_err", {31'h0, err}, 32'h0);
        apb_rd(4'h8, rd, err, w);
        check("thresh_rd", rd, 32'h3);
        apb_wr(4'h0, 32'h11, err);
        apb_wr(4'h0, 32'h22, err);
        @(posedge clk); #1;
        check("irq_below_thresh", {31'h0, irq}, 32'h0);
        apb_wr(4'h0, 32'h33, err);
        check("irq_level_lag", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_rise", {31'h0, irq}, 32'h1);
        apb_rd(4'h0, rd, err, w);
        check("irq_pop_data", rd, 32'h11);
        check("irq_fall", {31'h0, irq}, 32'h0);

        // Reset during POP
        apb.psel    = 1'b1;
        apb.pwrite  = 1'b0;
        apb.paddr   = 4'h0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(negedge clk);
        check("abort_rd_en", {31'h0, rd_en}, 32'h1);
        @(posedge clk); #1;
        check("abort_pop_pready", {31'h0, apb.pready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {29'h0, apb.pready, apb.pslverr, rd_en}, 32'h0);
        check("abort_prdata", apb.prdata, 32'h0);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_rd(4'h4, rd, err, w);
        check("status_after_abort", rd, 32'h0000_0001);
        apb_rd(4'h8, rd, err, w);
        check("thresh_after_abort", rd, 32'h0);
        check("irq_after_abort", {31'h0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_apb_ctrl.md
# fifo_apb_ctrl

APB3 slave controller that sequences the FIFO: APB writes push data, APB reads pop data. It also tracks occupancy and reports status, sticky error flags and a level interrupt. It sits between the APB interconnect and the FIFO's `wr_en`/`rd_en`/`din`/`dout`/`full`/`empty` pins. A top-level wrapper connects both blocks on the same `clk`/`rst_n`.

## Interface
Parameters:
- `DATA_WIDTH`, from `shared_pkg`, FIFO word width; must be ≤ 32.
- `FIFO_DEPTH`, from `shared_pkg` (8), number of FIFO entries.
- `ADDR_WIDTH`, 4, APB address width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data; zero-extended from DATA_WIDTH.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  error response; valid only with `pready`.
- `wr_en`, `rd_en`  out  1 each  FIFO push and pop strobes.
- `din`  out  DATA_WIDTH  FIFO write data.
- `dout`  in  DATA_WIDTH  FIFO read data; registered, valid 1 cycle after `rd_en`.
- `full`, `empty`  in  1 each  FIFO flags.
- `irq`  out  1  level interrupt, registered.

## Operation
Register map:
- 0x0 DATA: write pushes, read pops.
- 0x4 STATUS (RO):
  - [0] empty
  - [1] full
  - [2] ovf (sticky)
  - [3] udf (sticky)
  - [15:8] level
- 0x8 THRESH (RW): [7:0] threshold; reset value 0.
- 0xC CLEAR (WO): writing 1 to bit 2 clears ovf; writing 1 to bit 3 clears udf.

FSM states are IDLE, POP and RESP. An access phase is `psel & penable`.

In IDLE, on an access phase:
- Write to DATA, `!full`: `wr_en=1` and `din=pwdata[DATA_WIDTH-1:0]` for that cycle; `pready=1`, `pslverr=0`; stay in IDLE.
- Write to DATA, `full`: no `wr_en`; `pready=1`, `pslverr=1`; set ovf.
- Read from DATA, `!empty`: `rd_en=1` for exactly one cycle; go to POP; `pready=0`.
- Read from DATA, `empty`: no `rd_en`; `pready=1`, `pslverr=1`, `prdata=0`; set udf.
- STATUS/THRESH reads, and THRESH/CLEAR writes: `pready=1` with zero wait states.
- Write to STATUS, read from CLEAR, or any unmapped offset: `pready=1`, `pslverr=1`, `prdata=0`, no side effects.

Other states:
- POP: capture `dout` into the read holding register; go to RESP.
- RESP: `pready=1`, `prdata` = holding register; return to IDLE.

Level counter:
- Width `$clog2(FIFO_DEPTH)+1`.
- +1 on `wr_en`, −1 on `rd_en`. Both strobes can never be asserted in the same cycle, since there is one APB master.
- Saturates at 0 and FIFO_DEPTH. The FIFO's `full`/`empty` remain authoritative for push/pop decisions.

Interrupt and flags:
- `irq` is registered: `irq <= (THRESH != 0) && (level >= THRESH)`.
- If a CLEAR write and a new error occur in the same cycle, set wins.

## Timing
- Reset values: `prdata=0`, `pready=0`, `pslverr=0`, `wr_en=0`, `rd_en=0`, `din=0`, `irq=0`, FSM in IDLE, level 0, THRESH 0, ovf 0, udf 0.
- `pready`, `pslverr`, `wr_en`, `rd_en` and `prdata` are combinational from state, decode and the holding register. Outside a completing access they are 0.
- Latency:
  - Pushes, register accesses and error responses: 0 wait states.
  - Successful DATA read: exactly 2 wait states (IDLE→POP→RESP). `prdata` is valid in RESP.
- `rd_en`/`wr_en` pulse once per transfer. The access phase is not re-decoded while in POP or RESP.
- `irq` lags the level change by 1 cycle.
- Asserting `rst_n` low mid-transfer (including in POP or RESP) forces reset values immediately. The pending read is discarded; the FIFO shares `rst_n` and also clears.

## Structure
- `shared_pkg` holds:
  - `DATA_WIDTH`, which already exists there;
  - a new `FIFO_DEPTH` constant;
  - the register offset localparams `REG_DATA`, `REG_STATUS`, `REG_THRESH`, `REG_CLEAR`;
  - the state typedef `fifo_ctrl_state_e` {IDLE, POP, RESP}.
- No sub-module. The wrapper `apb_fifo_top` instantiates the FIFO and `fifo_apb_ctrl`.

## Test plan
All scenarios use DATA_WIDTH=16 and FIFO_DEPTH=8.
- Reset with no traffic → all outputs 0; STATUS read returns 0x0000_0001.
- Write 0xA5A5 to DATA, then read DATA → `wr_en` pulses for 1 cycle; the read completes after 2 wait states with `prdata=0x0000_A5A5` and `pslverr=0`; then STATUS=0x0000_0001.
- Write 9 words to DATA → the 9th gets `pslverr=1`; STATUS=0x0000_0806 (ovf set, full, level 8); write 0x4 to CLEAR → STATUS=0x0000_0802.
- Read DATA while empty → `pslverr=1`, `prdata=0`, no `rd_en`; STATUS bit3=1.
- Set THRESH=3, then push 3 words → `irq` rises 1 cycle after the 3rd `wr_en`; after 1 pop, `irq` falls 1 cycle after `rd_en`.
- Pull `rst_n` low during POP → `rd_en`/`pready` drop to 0 immediately and the FSM returns to IDLE; the next read of STATUS returns 0x0000_0001.
